fsb8_arb: RTL and testbench

FSB8_ARB -- requirements
Module: fsb8_arb

---
 rtl/fsb8_arb_if.sv | 22 ++
 rtl/fsb8_arb.sv | 116 +++++++++++
 tb/tb_fsb8_arb.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fsb8_arb_if.sv
// FSB8 arbiter bus bundle: request/lock/transfer-complete inputs and the
// registered grant outputs. Requesters drive through 'master'; the arbiter
// consumes through 'slave'.
interface fsb8_arb_if;
  logic [2:0] req;        // bit 0 = CPU, bit 1 = DMA, bit 2 = debug
  logic [2:0] lock;       // hold ownership across a burst
  logic       xfer_done;  // single-cycle hready pulse from the FSB8 bridge
  logic [2:0] grant;      // one-hot owner, or zero
  logic [1:0] gnt_id;     // encoded owner, 2'b11 when none
  logic       gnt_valid;  // high exactly when grant is non-zero
  logic       timeout;    // single-cycle pulse: owner revoked by watchdog

  modport master (
    output req, lock, xfer_done,
    input  grant, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, lock, xfer_done,
    output grant, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/fsb8_arb.sv
// FSB8 bridge arbiter: three requesters, round-robin selection, optional
// burst lock, one-cycle turnaround between owners and a watchdog that
// revokes an owner that never completes a transfer.
module fsb8_arb #(
  parameter int unsigned TMO_CYCLES = 255  // watchdog limit, 2..255 cycles
) (
  input logic       hclk,
  input logic       hreset,
  fsb8_arb_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] OWN      = 2'b01;
  localparam logic [1:0] REL      = 2'b10;
  localparam logic [1:0] NO_OWNER = 2'b11;

  // The counter value seen in the cycle whose edge would make it reach the
  // limit; revoking on that edge drops grant exactly TMO_CYCLES after it rose.
  localparam logic [7:0] WDOG_LAST = 8'(TMO_CYCLES - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [1:0] last_owner;
  logic [7:0] wdog;
  logic [2:0] grant_q;
  logic [1:0] gnt_id_q;
  logic       gnt_valid_q;
  logic       timeout_q;
  logic [1:0] winner;
  logic       owner_req;
  logic       owner_lock;
  logic       wdog_hit;
  logic       tmo_fire;

  // Round-robin pick: search starts one past the previous owner and wraps,
  // so the previous owner is considered last.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = NO_OWNER;
    idx  = last;
    for (int i = 0; i < 3; i++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (pick == NO_OWNER && r[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign winner     = rr_pick(bus.req, last_owner);
  // grant is one-hot while owning, so masking with it selects the owner's bit
  assign owner_req  = |(bus.req & grant_q);
  assign owner_lock = |(bus.lock & grant_q);
  assign wdog_hit   = (wdog >= WDOG_LAST);

  // Next-state decision; xfer_done outranks abandonment and the watchdog.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    tmo_fire  = 1'b0;
    case (state)
      IDLE: if (|bus.req) state_nxt = OWN;
      OWN: begin
        if (bus.xfer_done) begin
          if (!owner_lock) state_nxt = REL;
        end else if (!owner_req && !owner_lock) begin
          state_nxt = REL;
        end else if (wdog_hit) begin
          state_nxt = REL;
          tmo_fire  = 1'b1;
        end
      end
      REL:     state_nxt = (|bus.req) ? OWN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, registered grant outputs, watchdog and round-robin pointer.
  always_ff @(posedge hclk or posedge hreset) begin
    // NOTE: non-blocking assignments so every register here samples the
    // pre-edge values, independent of statement order.
    if (hreset) begin
      state       <= IDLE;
      grant_q     <= 3'b000;
      gnt_id_q    <= NO_OWNER;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      wdog        <= 8'd0;
      last_owner  <= 2'd2;
    end else begin
      state     <= state_nxt;
      timeout_q <= tmo_fire;
      if (state != OWN && state_nxt == OWN) begin
        grant_q     <= 3'b001 << winner;
        gnt_id_q    <= winner;
        gnt_valid_q <= 1'b1;
        wdog        <= 8'd0;
      end else if (state == OWN && state_nxt == REL) begin
        grant_q     <= 3'b000;
        gnt_id_q    <= NO_OWNER;
        gnt_valid_q <= 1'b0;
        wdog        <= 8'd0;
        last_owner  <= gnt_id_q;
      end else if (state == OWN) begin
        if (bus.xfer_done)      wdog <= 8'd0;
        else if (wdog != 8'hFF) wdog <= wdog + 8'd1;
      end
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_fsb8_arb.sv
// Scoreboard bench for fsb8_arb. Each stimulus vector drives one cycle of
// inputs and queues the outputs expected after the following edge; a monitor
// pops and compares on the falling edge of that cycle.
module tb_fsb8_arb;

  // Output tuple {grant, gnt_id, gnt_valid, timeout}
  localparam logic [6:0] NONE = {3'b000, 2'b11, 1'b0, 1'b0};
  localparam logic [6:0] TO   = {3'b000, 2'b11, 1'b0, 1'b1};
  localparam logic [6:0] G0   = {3'b001, 2'd0,  1'b1, 1'b0};
  localparam logic [6:0] G1   = {3'b010, 2'd1,  1'b1, 1'b0};
  localparam logic [6:0] G2   = {3'b100, 2'd2,  1'b1, 1'b0};

  typedef struct {
    int         due;
    logic [6:0] exp;
    string      name;
  } sb_entry_t;

  logic hclk;
  logic hreset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  sb_entry_t sb[$];
  sb_entry_t mon_e;

  fsb8_arb_if bus ();

  fsb8_arb #(.TMO_CYCLES(8)) dut (
    .hclk  (hclk),
    .hreset(hreset),
    .bus   (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  always @(posedge hclk) cyc <= cyc + 1;

  function automatic logic [6:0] outs();
    return {bus.grant, bus.gnt_id, bus.gnt_valid, bus.timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b (grant,gnt_id,gnt_valid,timeout) at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge; expect the result
  // after the next rising edge.
  task automatic apply(input logic [2:0] r, input logic [2:0] l, input logic xd,
                       input logic [6:0] e, input string nm);
    sb_entry_t ent;
    @(posedge hclk);
    #1;
    bus.req       = r;
    bus.lock      = l;
    bus.xfer_done = xd;
    ent.due  = cyc + 1;
    ent.exp  = e;
    ent.name = nm;
    sb.push_back(ent);
  endtask

  // Monitor: compare the outputs against the entry due this cycle.
  always @(negedge hclk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check(mon_e.name, {25'd0, outs()}, {25'd0, mon_e.exp});
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "global timeout");
  end

  initial begin
    bus.req       = 3'b000;
    bus.lock      = 3'b000;
    bus.xfer_done = 1'b0;
    hreset        = 1'b0;
    #1 hreset = 1'b1;
    #2 check("reset_state", {25'd0, outs()}, {25'd0, NONE});
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hreset = 1'b0;

    apply(3'b000, 3'b000, 1'b0, NONE, "idle_no_req");

    // Round robin with all requesting, xfer_done every 4 cycles
    apply(3'b111, 3'b000, 1'b0, G0, "rr_first_cpu");
    for (int i = 0; i < 3; i++) apply(3'b111, 3'b000, 1'b0, G0, "rr_cpu_hold");
    apply(3'b111, 3'b000, 1'b1, NONE, "rr_cpu_rel");
    apply(3'b111, 3'b000, 1'b0, G1, "rr_dma_grant");
    for (int i = 0; i < 2; i++) apply(3'b111, 3'b000, 1'b0, G1, "rr_dma_hold");
    apply(3'b111, 3'b000, 1'b1, NONE, "rr_dma_rel");
    apply(3'b111, 3'b000, 1'b0, G2, "rr_dbg_grant");
    for (int i = 0; i < 2; i++) apply(3'b111, 3'b000, 1'b0, G2, "rr_dbg_hold");
    apply(3'b111, 3'b000, 1'b1, NONE, "rr_dbg_rel");
    apply(3'b111, 3'b000, 1'b0, G0, "rr_wrap_cpu");

    // Owner drops req without lock before any transfer
    apply(3'b000, 3'b000, 1'b0, NONE, "abandon_rel");
    apply(3'b000, 3'b000, 1'b0, NONE, "rel_to_idle");
    apply(3'b000, 3'b000, 1'b1, NONE, "xfer_done_idle_ignored");

    // Locked DMA burst: four transfers, lock released on the last
    apply(3'b010, 3'b010, 1'b0, G1, "burst_grant");
    apply(3'b010, 3'b010, 1'b1, G1, "burst_done1");
    apply(3'b111, 3'b111, 1'b0, G1, "burst_nonowner_noise");
    apply(3'b010, 3'b010, 1'b1, G1, "burst_done2");
    apply(3'b010, 3'b010, 1'b0, G1, "burst_gap");
    apply(3'b010, 3'b010, 1'b1, G1, "burst_done3");
    apply(3'b010, 3'b010, 1'b0, G1, "burst_gap2");
    apply(3'b010, 3'b000, 1'b1, NONE, "burst_done4_rel");
    apply(3'b000, 3'b000, 1'b0, NONE, "burst_idle");

    // Watchdog: grant rises, 8 cycles later timeout with grant dropped
    apply(3'b001, 3'b000, 1'b0, G0, "tmo_grant");
    for (int i = 0; i < 7; i++) apply(3'b001, 3'b000, 1'b0, G0, "tmo_count");
    apply(3'b001, 3'b000, 1'b0, TO, "tmo_fire");
    apply(3'b001, 3'b000, 1'b0, G0, "tmo_regrant");

    // xfer_done coincident with the watchdog limit, unlocked
    for (int i = 0; i < 7; i++) apply(3'b001, 3'b000, 1'b0, G0, "lim_count");
    apply(3'b001, 3'b000, 1'b1, NONE, "lim_done_no_tmo");

    // Same collision with lock held: owner stays, watchdog restarts
    apply(3'b100, 3'b100, 1'b0, G2, "lock_grant");
    for (int i = 0; i < 7; i++) apply(3'b100, 3'b100, 1'b0, G2, "lock_count");
    apply(3'b100, 3'b100, 1'b1, G2, "lock_done_at_limit");
    apply(3'b100, 3'b100, 1'b0, G2, "lock_wdog_cleared");

    // Asynchronous reset while debug owns the bus
    @(posedge hclk);
    @(negedge hclk);
    #1;
    hreset = 1'b1;
    #1 check("reset_async_drop", {25'd0, outs()}, {25'd0, NONE});
    bus.req  = 3'b101;
    bus.lock = 3'b000;
    @(posedge hclk);
    #1 check("reset_hold_no_grant", {25'd0, outs()}, {25'd0, NONE});
    bus.req = 3'b000;
    @(negedge hclk);
    hreset = 1'b0;

    apply(3'b101, 3'b000, 1'b0, G0, "post_reset_first");
    apply(3'b101, 3'b000, 1'b1, NONE, "post_reset_rel");
    apply(3'b101, 3'b000, 1'b0, G2, "post_reset_rr");
    apply(3'b000, 3'b000, 1'b0, NONE, "final_abandon");

    @(posedge hclk);
    @(negedge hclk);
    #1 check("scoreboard_drain", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
